// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branch directions, resolved oldest-first; mispredict flushes all younger entries.
// Optional macro BRQ_STATS_EN builds saturating hit/miss counters; otherwise hit_cnt/miss_cnt are tied to 0.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     result,
  output logic                     taken,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             result_q, result_d, taken_q, taken_d, mis_q, mis_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             popOk, missHit, hitOk, pushOk;

  // A wrong-path push (same cycle as a mispredict) is dropped; a correct pop frees a slot for a push.
  always_comb begin
    popOk   = resolve_valid && (count_q != '0);
    missHit = popOk && (mem_q[rptr_q] != resolve_taken);
    hitOk   = popOk && !missHit;
    pushOk  = pred_valid && !missHit && ((count_q != DEPTH_C) || hitOk);

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (missHit) begin
      wptr_d  = rptr_q;
      count_d = '0;
    end else begin
      if (pushOk) begin
        mem_d[wptr_q] = pred_taken;
        wptr_d        = wptr_q + PW'(1);
      end
      if (hitOk) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(pushOk) - CW'(hitOk);
    end

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    result_d = popOk;
    taken_d  = popOk ? resolve_taken : taken_q;
    mis_d    = missHit;
    ovf_d    = ovf_q || (pred_valid && (count_q == DEPTH_C) && !popOk);
    unf_d    = unf_q || (resolve_valid && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      result_q <= 1'b0;
      taken_q  <= 1'b0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      mis_q    <= mis_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] hit_q, miss_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hitOk && (hit_q != '1))    hit_q  <= hit_q + CNT_W'(1);
      if (missHit && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  assign result        = result_q;
  assign taken         = taken_q;
  assign mispredict    = mis_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign count         = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed vector table plus randomized run against a queue-based reference model.
// Statistics expectations follow BRQ_STATS_EN (zero when the macro is undefined).
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef BRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, pred_valid, pred_taken, resolve_valid, resolve_taken;
  logic result, taken, mispredict, full, empty, overflow_err, underflow_err;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .result(result), .taken(taken), .mispredict(mispredict),
    .full(full), .empty(empty), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rstN, pv, pt, rv, rt;
    bit res, tk, mis;
    int cnt;
    bit emp, ful, ovf, unf;
    int hit, miss;
  } vec_t;

  vec_t vecs[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit mq[$];
  bit mRes, mTk, mMis, mOvf, mUnf;
  int mHit, mMiss;

  function automatic void addVec(bit rstN, bit pv, bit pt, bit rv, bit rt,
                                 bit res, bit tk, bit mis, int cnt, bit emp, bit ful,
                                 bit ovf, bit unf, int hit, int miss);
    vec_t v;
    v.rstN = rstN; v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt;
    v.res = res; v.tk = tk; v.mis = mis; v.cnt = cnt; v.emp = emp; v.ful = ful;
    v.ovf = ovf; v.unf = unf; v.hit = hit; v.miss = miss;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(bit rstN, bit pv, bit pt, bit rv, bit rt);
    rst_n = rstN; pred_valid = pv; pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, string field, int act, int expv);
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", tag, field, act, expv);
    end
  endtask

  task automatic checkOutput(string tag, bit res, bit tk, bit mis, int cnt, bit emp,
                             bit ful, bit ovf, bit unf, int hit, int miss);
    vectors++;
    cmp(tag, "result", int'(result), int'(res));
    cmp(tag, "taken", int'(taken), int'(tk));
    cmp(tag, "mispredict", int'(mispredict), int'(mis));
    cmp(tag, "count", int'(count), cnt);
    cmp(tag, "empty", int'(empty), int'(emp));
    cmp(tag, "full", int'(full), int'(ful));
    cmp(tag, "overflow_err", int'(overflow_err), int'(ovf));
    cmp(tag, "underflow_err", int'(underflow_err), int'(unf));
    cmp(tag, "hit_cnt", int'(hit_cnt), STATS ? hit : 0);
    cmp(tag, "miss_cnt", int'(miss_cnt), STATS ? miss : 0);
  endtask

  task automatic modelStep(bit rstN, bit pv, bit pt, bit rv, bit rt);
    int sz;
    bit acc, m;
    if (!rstN) begin
      mq.delete();
      mRes = 0; mTk = 0; mMis = 0; mOvf = 0; mUnf = 0; mHit = 0; mMiss = 0;
      return;
    end
    sz  = mq.size();
    acc = rv && (sz > 0);
    m   = 1'b0;
    if (rv && sz == 0) mUnf = 1'b1;
    if (pv && sz == DEPTH && !acc) mOvf = 1'b1;
    mRes = acc;
    mMis = 1'b0;
    if (acc) begin
      mTk = rt;
      m   = (mq[0] != rt);
      mMis = m;
      if (m) begin
        mq.delete();
        if (mMiss < SAT) mMiss++;
      end else begin
        void'(mq.pop_front());
        if (mHit < SAT) mHit++;
      end
    end
    if (pv && !m && mq.size() < DEPTH) mq.push_back(pt);
  endtask

  initial begin
    rst_n = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;

    //     rst pv pt rv rt | res tk mis cnt emp ful ovf unf hit miss
    addVec(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0,   0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 1,   1, 1, 0, 2, 0, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0, 0, 2, 0);
    addVec(1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 2, 0);
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 2, 0, 0, 0, 0, 2, 0);
    addVec(1, 1, 1, 0, 0,   0, 0, 0, 3, 0, 0, 0, 0, 2, 0);
    addVec(1, 1, 0, 0, 0,   0, 0, 0, 4, 0, 1, 0, 0, 2, 0);
    addVec(1, 1, 1, 0, 0,   0, 0, 0, 4, 0, 1, 1, 0, 2, 0);
    addVec(1, 1, 1, 1, 1,   1, 1, 0, 4, 0, 1, 1, 0, 3, 0);
    addVec(1, 0, 0, 1, 0,   1, 0, 0, 3, 0, 0, 1, 0, 4, 0);
    addVec(1, 1, 1, 1, 0,   1, 0, 1, 0, 1, 0, 1, 0, 4, 1);
    addVec(1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 4, 1);
    addVec(1, 1, 1, 1, 1,   0, 0, 0, 1, 0, 0, 1, 1, 4, 1);
    addVec(1, 1, 0, 1, 1,   1, 1, 0, 1, 0, 0, 1, 1, 5, 1);
    addVec(1, 1, 1, 1, 0,   1, 0, 0, 1, 0, 0, 1, 1, 6, 1);
    addVec(1, 1, 1, 0, 0,   0, 0, 0, 2, 0, 0, 1, 1, 6, 1);
    addVec(0, 1, 1, 1, 1,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt);
      checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].tk, vecs[i].mis,
                  vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf,
                  vecs[i].hit, vecs[i].miss);
    end

    // Randomized run; resolves mostly agree with the model's oldest entry to reach full and saturate.
    for (int c = 0; c < 3000; c++) begin
      bit rstN, pv, pt, rv, rt;
      rstN = (c == 0) ? 1'b0 : ($urandom_range(99) >= 2);
      pv   = $urandom_range(1);
      pt   = $urandom_range(1);
      rv   = ($urandom_range(2) == 0);
      if (mq.size() > 0 && $urandom_range(3) != 0) rt = mq[0];
      else rt = $urandom_range(1);
      applyStimulus(rstN, pv, pt, rv, rt);
      modelStep(rstN, pv, pt, rv, rt);
      checkOutput($sformatf("rand%0d", c), mRes, mTk, mMis, mq.size(),
                  mq.size() == 0, mq.size() == DEPTH, mOvf, mUnf, mHit, mMiss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, outstanding-branch capacity (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have one clock; reset is synchronous and active-low (clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 pred_valid  input  1  a predicted branch issues this cycle; push request.
REQ-007 pred_taken  input  1  predicted direction of the issuing branch.
REQ-008 resolve_valid  input  1  oldest outstanding branch resolves this cycle; pop request.
REQ-009 resolve_taken  input  1  actual direction of the resolving branch.
REQ-010 result  output  1  one-cycle pulse telling the predictor to update its counter.
REQ-011 taken  output  1  actual direction qualified by result.
REQ-012 mispredict  output  1  one-cycle pulse; resolved direction differed from prediction.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 count  output  $clog2(DEPTH)+1  number of outstanding entries.
REQ-016 overflow_err  output  1  sticky; push attempted while full with no pop.
REQ-017 underflow_err  output  1  sticky; resolve attempted while empty.
REQ-018 hit_cnt  output  CNT_W  correct-prediction count.
REQ-019 miss_cnt  output  CNT_W  misprediction count.

Function
REQ-020 SHALL store pred_taken in an in-order circular FIFO of DEPTH entries (write pointer, read pointer, occupancy counter).
REQ-021 SHALL compare resolve_taken against the oldest entry when resolve_valid is high and empty is low.
REQ-022 SHALL register result=1, taken=resolve_taken the cycle after an accepted resolve; otherwise result=0 and taken holds its last value.
REQ-023 SHALL pulse mispredict for exactly one cycle, aligned with result, when the compared entry != resolve_taken.
REQ-024 On mispredict, SHALL discard the resolving entry and every younger entry (pointers equal, count=0 next cycle); a same-cycle pred_valid SHALL be dropped as wrong-path.
REQ-025 On correct resolve, SHALL pop exactly one entry; a same-cycle push SHALL also be accepted, count unchanged.
REQ-026 Push while full with an accepted correct resolve in the same cycle SHALL be accepted (pop frees the slot).
REQ-027 Push while full and no accepted pop SHALL be dropped, count unchanged, overflow_err set.
REQ-028 resolve_valid while empty SHALL be ignored (no result, no mispredict), underflow_err set; a simultaneous push SHALL still be accepted.
REQ-029 Pointers SHALL wrap modulo DEPTH; full, empty and count SHALL be registered and valid the cycle after the causing event.
REQ-030 overflow_err and underflow_err SHALL clear only on reset.

Reset
REQ-031 While rst_n is low at a clk edge: pointers=0, count=0, empty=1, full=0, result=0, taken=0, mispredict=0, overflow_err=0, underflow_err=0, hit_cnt=0, miss_cnt=0.
REQ-032 Reset SHALL take priority over every simultaneous push/resolve; a reset mid-operation discards all outstanding entries and produces no result pulse.

Configuration
REQ-033 Macro BRQ_STATS_EN SHALL, when defined, enable hit_cnt (+1 per correct resolve) and miss_cnt (+1 per mispredict), each saturating at 2^CNT_W-1.
REQ-034 Without BRQ_STATS_EN, hit_cnt and miss_cnt SHALL be ports tied to 0 and no counter registers SHALL be built.

Verification
REQ-035 Reset; push taken,not-taken,taken (3 cycles) -> count=3, empty=0, full=0, no result pulses.
REQ-036 Then resolve 1,0 correct -> result pulses on the two following cycles with taken=1 then 0, mispredict=0, count=1, hit_cnt=2 (stats build).
REQ-037 DEPTH=4: fill 4 entries, push again without resolve -> push dropped, count=4, overflow_err=1; push plus correct resolve in same cycle -> count stays 4.
REQ-038 3 entries queued, resolve oldest (predicted 1) with resolve_taken=0 plus same-cycle push -> next cycle mispredict=1, result=1, taken=0, count=0, empty=1, miss_cnt=1.
REQ-039 Empty queue, resolve_valid=1 -> no result, underflow_err=1; 10 push/resolve cycles through DEPTH=4 -> pointers wrap, all outputs match in-order model.
REQ-040 Assert rst_n=0 with 2 entries queued and resolve_valid=1 -> next cycle all outputs at reset values, no result pulse.
